// File: rtl/fpu_pkg.sv
// fpu_pkg: shared latency defaults, FP opcodes and writeback slot type
package fpu_pkg;
  localparam int LOAD_LAT_D = 2;
  localparam int ADSB_LAT_D = 3;
  localparam int MULT_LAT_D = 2;
  localparam int CVRT_LAT_D = 1;
  localparam int MAX_LAT_D = 4;
  localparam logic [6:0] OPC_OP_FP = 7'b1010011;
  localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
  typedef struct packed {
    logic valid;
    logic [4:0] rd;
    logic to_int;
  } slot_t;
endpackage

// File: rtl/fpu_wb_shifter.sv
// fpu_wb_shifter: writeback reservation shifter, slot 1 is the current writeback
module fpu_wb_shifter
  import fpu_pkg::*;
#(
  parameter int MAX_LAT = 4,
  parameter int LW = $clog2(MAX_LAT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic ins_valid,
  input  logic [LW-1:0] ins_lat,
  input  slot_t ins_slot,
  input  logic [LW-1:0] query_lat,
  output logic query_occ,
  output slot_t head,
  output logic busy
);
  slot_t s [1:MAX_LAT];
  slot_t shifted [1:MAX_LAT];
  // contents each slot would hold after this cycle's shift, before insertion
  always_comb begin
    for (int k = 1; k < MAX_LAT; k++) shifted[k] = s[k+1];
    shifted[MAX_LAT] = '0;
  end
  // any reservation outstanding, including the one on the writeback port
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) busy = busy | s[k].valid;
  end
  assign query_occ = shifted[query_lat].valid;
  assign head = s[1];
  // shift every cycle; a new reservation lands at its latency slot
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 1; k <= MAX_LAT; k++) s[k] <= '0;
    end else begin
      for (int k = 1; k <= MAX_LAT; k++) s[k] <= shifted[k];
      if (ins_valid) s[ins_lat] <= ins_slot;
    end
  end
endmodule

// File: rtl/fpu_issue.sv
// fpu_issue: in-order FP issue with RAW/WAW stalls and single writeback port scheduling
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int LOAD_LAT = LOAD_LAT_D,
  parameter int ADSB_LAT = ADSB_LAT_D,
  parameter int MULT_LAT = MULT_LAT_D,
  parameter int CVRT_LAT = CVRT_LAT_D,
  parameter int MAX_LAT = MAX_LAT_D
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic reg_write,
  input  logic is_load,
  input  logic is_adsb,
  input  logic is_mult,
  input  logic is_cvrt,
  input  logic is_ftoi,
  input  logic use_rs1,
  input  logic use_rs2,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  input  logic flush,
  output logic issue_load,
  output logic issue_adsb,
  output logic issue_mult,
  output logic issue_cvrt,
  output logic wb_valid,
  output logic [4:0] wb_rd,
  output logic wb_to_int,
  output logic busy
);
  localparam int LW = $clog2(MAX_LAT + 1);
  logic [31:0] pending;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [LW-1:0] lat;
  logic fp_wr;
  logic occ;
  logic fire;
  slot_t head;
  assign lat = is_load ? LW'(LOAD_LAT) : is_adsb ? LW'(ADSB_LAT) : is_mult ? LW'(MULT_LAT) : LW'(CVRT_LAT);
  assign fp_wr = reg_write & ~is_ftoi;
  assign in_ready = ~(rst | flush | (use_rs1 & pending[rs1]) | (use_rs2 & pending[rs2]) | (fp_wr & pending[rd]) | (reg_write & occ));
  assign fire = in_valid & in_ready;
  assign issue_load = fire & is_load;
  assign issue_adsb = fire & ~is_load & is_adsb;
  assign issue_mult = fire & ~is_load & ~is_adsb & is_mult;
  assign issue_cvrt = fire & ~is_load & ~is_adsb & ~is_mult & (is_cvrt | reg_write);
  assign wb_valid = head.valid;
  assign wb_rd = head.rd;
  assign wb_to_int = head.to_int;
  assign clr_mask = (head.valid & ~head.to_int) ? 32'd1 << head.rd : 32'd0;
  assign set_mask = (fire & fp_wr) ? 32'd1 << rd : 32'd0;
  fpu_wb_shifter #(.MAX_LAT(MAX_LAT), .LW(LW)) u_shifter (
    .clk(clk),
    .rst(rst),
    .clear(flush),
    .ins_valid(fire & reg_write),
    .ins_lat(lat),
    .ins_slot('{valid: 1'b1, rd: rd, to_int: is_ftoi}),
    .query_lat(lat),
    .query_occ(occ),
    .head(head),
    .busy(busy)
  );
  // pending FP destinations: set at issue, cleared once the writeback cycle has passed
  always_ff @(posedge clk) begin
    if (rst || flush) pending <= '0;
    else pending <= (pending & ~clr_mask) | set_mask;
  end
endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: randomized and directed checks against a cycle-scheduled reference model
module tb_fpu_issue;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, reg_write, is_load, is_adsb, is_mult, is_cvrt, is_ftoi;
  logic use_rs1, use_rs2, flush;
  logic [4:0] rs1, rs2, rd, wb_rd;
  logic issue_load, issue_adsb, issue_mult, issue_cvrt, wb_valid, wb_to_int, busy;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit s_v [0:4095];
  bit [4:0] s_rd [0:4095];
  bit s_ti [0:4095];
  int pend_end [0:31];
  bit m_fire;
  int m_lat;
  logic [12:0] exp_vec;

  fpu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .reg_write(reg_write),
    .is_load(is_load), .is_adsb(is_adsb), .is_mult(is_mult), .is_cvrt(is_cvrt), .is_ftoi(is_ftoi),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush),
    .issue_load(issue_load), .issue_adsb(issue_adsb), .issue_mult(issue_mult), .issue_cvrt(issue_cvrt),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_to_int(wb_to_int), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs_vec();
    return {in_ready, issue_load, issue_adsb, issue_mult, issue_cvrt, wb_valid, wb_rd, wb_to_int, busy};
  endfunction

  // kind: 0 idle, 1 load, 2 add/sub, 3 mult, 4 convert, 5 float-to-int
  task automatic set_op(input int kind, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                        input logic ua, input logic ub);
    in_valid = kind != 0;
    is_load = kind == 1;
    is_adsb = kind == 2;
    is_mult = kind == 3;
    is_cvrt = kind == 4 || kind == 5;
    is_ftoi = kind == 5;
    reg_write = kind != 0;
    rd = d; rs1 = a; rs2 = b;
    use_rs1 = ua && kind != 0;
    use_rs2 = ub && kind != 0;
  endtask

  // expected outputs for the current cycle from the writeback calendar and pending deadlines
  task automatic eval_cycle();
    bit rdy, any;
    #2;
    m_lat = is_load ? 2 : is_adsb ? 3 : is_mult ? 2 : 1;
    rdy = !rst && !flush;
    if (use_rs1 && pend_end[rs1] >= cyc) rdy = 0;
    if (use_rs2 && pend_end[rs2] >= cyc) rdy = 0;
    if (reg_write && !is_ftoi && pend_end[rd] >= cyc) rdy = 0;
    if (reg_write && s_v[cyc + m_lat]) rdy = 0;
    m_fire = in_valid && rdy;
    any = 0;
    for (int k = 0; k <= 4; k++) any = any | s_v[cyc + k];
    exp_vec = {rdy, m_fire && is_load, m_fire && !is_load && is_adsb,
               m_fire && !is_load && !is_adsb && is_mult,
               m_fire && !is_load && !is_adsb && !is_mult && (is_cvrt || reg_write),
               s_v[cyc], s_v[cyc] ? s_rd[cyc] : 5'd0, s_v[cyc] ? s_ti[cyc] : 1'b0, any};
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst || flush) begin
      for (int k = cyc + 1; k <= cyc + 8; k++) s_v[k] = 0;
      for (int r = 0; r < 32; r++) pend_end[r] = -1;
    end else if (m_fire && reg_write) begin
      s_v[cyc + m_lat] = 1;
      s_rd[cyc + m_lat] = rd;
      s_ti[cyc + m_lat] = is_ftoi;
      if (!is_ftoi) pend_end[rd] = cyc + m_lat;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; flush = 0;
    set_op(2, 5'd5, 5'd1, 5'd2, 1, 1);
    repeat (3) begin
      eval_cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL reset_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
      n_cmp++;
      if ({in_ready, issue_load, issue_adsb, issue_mult, issue_cvrt, wb_valid, wb_rd, wb_to_int, busy} !== 13'd0) begin
        n_bad++; $display("FAIL reset_zero cyc=%0d got=%b exp=0", cyc, obs_vec());
      end
      commit();
    end
    rst = 0;
    set_op(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_single_adsb();
    int t0, wbc;
    logic [4:0] wrd;
    wbc = -1; wrd = 0;
    set_op(2, 5'd5, 5'd0, 5'd0, 0, 0);
    eval_cycle();
    t0 = cyc;
    n_cmp++;
    if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL adsb_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
    n_cmp++;
    if (issue_adsb !== 1'b1) begin n_bad++; $display("FAIL adsb_issue got=%b exp=1", issue_adsb); end
    commit();
    set_op(0, 0, 0, 0, 0, 0);
    repeat (5) begin
      eval_cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL adsb_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
      if (wb_valid === 1'b1) begin wbc = cyc; wrd = wb_rd; end
      commit();
    end
    n_cmp++;
    if (wbc - t0 !== 3 || wrd !== 5'd5) begin n_bad++; $display("FAIL adsb_wb lat=%0d rd=%0d exp lat=3 rd=5", wbc - t0, wrd); end
    set_op(2, 5'd6, 5'd5, 5'd5, 1, 1);
    eval_cycle();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL adsb_pend_clear got=%b exp=1", in_ready); end
    commit();
    set_op(0, 0, 0, 0, 0, 0);
    repeat (4) begin eval_cycle(); commit(); end
  endtask

  task automatic test_raw();
    int t0, ic, cnt;
    ic = -1; cnt = 0;
    set_op(3, 5'd3, 5'd0, 5'd0, 0, 0);
    eval_cycle();
    t0 = cyc;
    n_cmp++;
    if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL raw_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
    commit();
    for (int i = 0; i < 10 && ic < 0; i++) begin
      set_op(2, 5'd9, 5'd3, 5'd0, 1, 0);
      eval_cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL raw_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
      if (issue_adsb === 1'b1) begin ic = cyc; cnt++; end
      commit();
    end
    set_op(0, 0, 0, 0, 0, 0);
    repeat (5) begin
      eval_cycle();
      if (issue_adsb === 1'b1) cnt++;
      commit();
    end
    n_cmp++;
    if (ic - t0 !== 3 || cnt !== 1) begin n_bad++; $display("FAIL raw_hold issue_at=+%0d pulses=%0d exp +3 and 1", ic - t0, cnt); end
  endtask

  task automatic test_collision();
    int t0, ic, nwb, w0, w1;
    ic = -1; nwb = 0; w0 = -1; w1 = -1;
    set_op(2, 5'd10, 5'd0, 5'd0, 0, 0);
    eval_cycle();
    t0 = cyc;
    commit();
    for (int i = 0; i < 12; i++) begin
      if (ic < 0) set_op(3, 5'd11, 5'd1, 5'd2, 1, 1);
      else set_op(0, 0, 0, 0, 0, 0);
      eval_cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL coll_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
      if (issue_mult === 1'b1) ic = cyc;
      if (wb_valid === 1'b1) begin
        if (nwb == 0) w0 = cyc - t0; else w1 = cyc - t0;
        nwb++;
      end
      commit();
    end
    set_op(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (ic - t0 !== 2 || w0 !== 3 || w1 !== 4 || nwb !== 2) begin
      n_bad++; $display("FAIL coll_sched mult_at=+%0d wb=+%0d,+%0d n=%0d exp +2 wb +3,+4 n=2", ic - t0, w0, w1, nwb);
    end
  endtask

  task automatic test_ftoi();
    set_op(5, 5'd7, 5'd0, 5'd0, 0, 0);
    eval_cycle();
    n_cmp++;
    if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL ftoi_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
    commit();
    set_op(2, 5'd13, 5'd7, 5'd7, 1, 1);
    eval_cycle();
    n_cmp++;
    if ({wb_valid, wb_to_int, wb_rd, in_ready, issue_adsb} !== {1'b1, 1'b1, 5'd7, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL ftoi_wb got wbv=%b ti=%b rd=%0d rdy=%b iss=%b exp 1 1 7 1 1", wb_valid, wb_to_int, wb_rd, in_ready, issue_adsb);
    end
    commit();
    set_op(0, 0, 0, 0, 0, 0);
    repeat (5) begin
      eval_cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL ftoi_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
      commit();
    end
  endtask

  task automatic test_flush();
    int nwb;
    nwb = 0;
    for (int i = 0; i < 3; i++) begin
      set_op(i == 0 ? 1 : i == 1 ? 2 : 4, 5'(i + 1), 5'd0, 5'd0, 0, 0);
      eval_cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL flush_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
      commit();
    end
    set_op(0, 0, 0, 0, 0, 0);
    flush = 1;
    eval_cycle();
    n_cmp++;
    if (obs_vec() !== exp_vec || wb_valid !== 1'b1) begin n_bad++; $display("FAIL flush_cycle got=%b exp=%b", obs_vec(), exp_vec); end
    commit();
    flush = 0;
    set_op(1, 5'd2, 5'd2, 5'd3, 1, 1);
    eval_cycle();
    n_cmp++;
    if ({busy, wb_valid, in_ready, issue_load} !== 4'b0011) begin
      n_bad++; $display("FAIL flush_after busy=%b wbv=%b rdy=%b iss=%b exp 0 0 1 1", busy, wb_valid, in_ready, issue_load);
    end
    commit();
    set_op(0, 0, 0, 0, 0, 0);
    repeat (4) begin
      eval_cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL flush_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
      if (wb_valid === 1'b1) nwb++;
      commit();
    end
    n_cmp++;
    if (nwb !== 1) begin n_bad++; $display("FAIL flush_drain wbs=%0d exp=1", nwb); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      {reg_write, is_load, is_adsb, is_mult, is_cvrt, is_ftoi} = 6'($urandom);
      is_load = is_load & ($urandom_range(0, 2) == 0);
      {use_rs1, use_rs2} = 2'($urandom);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      flush = $urandom_range(0, 24) == 0;
      eval_cycle();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL rand_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec); end
      commit();
    end
    flush = 0;
    set_op(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) pend_end[r] = -1;
    rst = 1; flush = 0;
    set_op(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    repeat (2) begin eval_cycle(); commit(); end
    test_single_adsb();
    test_raw();
    test_collision();
    test_ftoi();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
